// File: rtl/lfsr_gen.sv
// Fibonacci LFSR random word generator with a valid/ready output and a
// seed loader that substitutes SEED for the all-zero lockup state.
module lfsr_gen #(
    parameter int          WIDTH = 8,
    parameter logic [31:0] TAPS  = 32'h0000_00B8,
    parameter logic [31:0] SEED  = 32'd42,
    parameter int          OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic             rand_valid_o,
    input  logic             rand_ready_i,
    output logic [OUT_W-1:0] rand_o,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o
);

    localparam int CW = $clog2(OUT_W + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fsm_t;

    fsm_t             fsm;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [OUT_W-1:0] coll;
    logic [OUT_W-1:0] coll_nxt;
    logic [CW-1:0]    cnt;
    logic             fb;
    logic             last;
    logic             seed_zero;

    assign fb        = ^(lfsr & TAPS[WIDTH-1:0]);
    assign lfsr_nxt  = {lfsr[WIDTH-2:0], fb};
    // Oldest feedback bit drifts up to the MSB of the word
    assign coll_nxt  = OUT_W'({coll, fb});
    assign last      = (cnt == CW'(OUT_W - 1));
    assign seed_zero = (seed_i == '0);
    assign state_o   = lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr         <= SEED[WIDTH-1:0];
            coll         <= '0;
            cnt          <= '0;
            rand_o       <= '0;
            rand_valid_o <= 1'b0;
            lockup_o     <= 1'b0;
            fsm          <= FILL;
        end else begin
            lockup_o <= 1'b0;
            if (seed_load_i) begin
                lfsr         <= seed_zero ? SEED[WIDTH-1:0] : seed_i;
                lockup_o     <= seed_zero;
                coll         <= '0;
                cnt          <= '0;
                rand_valid_o <= 1'b0;
                fsm          <= FILL;
            end else begin
                unique case (fsm)
                    FILL: begin
                        if (en_i) begin
                            lfsr <= lfsr_nxt;
                            if (last) begin
                                rand_o       <= coll_nxt;
                                rand_valid_o <= 1'b1;
                                coll         <= '0;
                                cnt          <= '0;
                                fsm          <= HOLD;
                            end else begin
                                coll <= coll_nxt;
                                cnt  <= cnt + CW'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (rand_ready_i) begin
                            rand_valid_o <= 1'b0;
                            fsm          <= FILL;
                        end
                    end
                    default: fsm <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: default 8-bit words plus a 4-bit
// word instance sharing the same stimulus.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       ready = 1'b0;

    logic       valid;
    logic [7:0] rnd;
    logic [7:0] state;
    logic       lockup;

    logic       valid4;
    logic [3:0] rnd4;
    logic [7:0] state4;
    logic       lockup4;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    logic [7:0] seq[9] = '{8'h2A, 8'h54, 8'hA9, 8'h53, 8'hA7,
                           8'h4E, 8'h9D, 8'h3B, 8'h77};

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .seed_load_i  (seed_load),
        .seed_i       (seed),
        .rand_valid_o (valid),
        .rand_ready_i (ready),
        .rand_o       (rnd),
        .state_o      (state),
        .lockup_o     (lockup)
    );

    lfsr_gen #(.OUT_W(4)) dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .seed_load_i  (seed_load),
        .seed_i       (seed),
        .rand_valid_o (valid4),
        .rand_ready_i (ready),
        .rand_o       (rnd4),
        .state_o      (state4),
        .lockup_o     (lockup4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] step8(input logic [7:0] s);
        logic f;
        f = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], f};
    endfunction

    function automatic logic [7:0] gen_word(input logic [7:0] s0);
        logic [7:0] s;
        logic [7:0] w;
        s = s0;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w = {w[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
            s = step8(s);
        end
        return w;
    endfunction

    task automatic sb_check(input string tag);
        if (sb.size() == 0)
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        else
            check(tag, 32'(rnd), 32'(sb.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick();
        tick();
        check("rst_state", 32'(state), 32'h2A);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_lockup", 32'(lockup), 32'd0);
        check("rst_rand", 32'(rnd), 32'd0);
        check("rst_rand4", 32'(rnd4), 32'd0);
        rst = 1'b0;

        // first word, default sequence
        en = 1'b1;
        sb.push_back(gen_word(8'h2A));
        for (int k = 0; k < 8; k++) begin
            check($sformatf("seq%0d", k), 32'(state), 32'(seq[k]));
            check($sformatf("valid_fill%0d", k), 32'(valid), 32'd0);
            if (k == 3) check("w4_early", 32'(valid4), 32'd0);
            if (k == 4) begin
                check("w4_valid", 32'(valid4), 32'd1);
                check("w4_word", 32'(rnd4), 32'h7);
                check("w4_state", 32'(state4), 32'hA7);
            end
            tick();
        end
        check("seq8", 32'(state), 32'h77);
        check("valid_first", 32'(valid), 32'd1);
        check("word_const", 32'(rnd), 32'h77);
        sb_check("word_first");

        // backpressure: everything frozen
        for (int k = 0; k < 5; k++) begin
            check("hold_rand", 32'(rnd), 32'h77);
            check("hold_state", 32'(state), 32'h77);
            check("hold_valid", 32'(valid), 32'd1);
            tick();
        end
        ready = 1'b1;
        tick();
        check("hs_valid", 32'(valid), 32'd0);
        check("hs_nostep", 32'(state), 32'h77);
        ready = 1'b0;
        tick();
        check("resume", 32'(state), 32'(step8(8'h77)));
        en = 1'b0;

        // zero seed -> lockup substitution
        seed_load = 1'b1;
        seed = 8'h00;
        tick();
        seed_load = 1'b0;
        check("zseed_state", 32'(state), 32'h2A);
        check("zseed_lockup", 32'(lockup), 32'd1);
        check("zseed_valid", 32'(valid), 32'd0);
        tick();
        check("zseed_pulse", 32'(lockup), 32'd0);
        check("zseed_hold", 32'(state), 32'h2A);

        // fill, then seed load overrides pending handshake
        en = 1'b1;
        sb.push_back(gen_word(8'h2A));
        repeat (8) tick();
        check("refill_valid", 32'(valid), 32'd1);
        sb_check("word_refill");
        seed_load = 1'b1;
        seed = 8'h01;
        ready = 1'b1;
        tick();
        seed_load = 1'b0;
        ready = 1'b0;
        check("seed1_valid", 32'(valid), 32'd0);
        check("seed1_state", 32'(state), 32'h01);
        check("seed1_lockup", 32'(lockup), 32'd0);
        sb.push_back(gen_word(8'h01));
        repeat (7) tick();
        check("seed1_notyet", 32'(valid), 32'd0);
        tick();
        check("seed1_wvalid", 32'(valid), 32'd1);
        sb_check("word_seed1");
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("seed1_hs", 32'(valid), 32'd0);

        // toggled enable: 8 enabled cycles over 16 clocks
        en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.push_back(gen_word(8'h2A));
        for (int i = 0; i < 16; i++) begin
            en = (i % 2 == 0);
            if (i == 14) check("tog_notyet", 32'(valid), 32'd0);
            tick();
        end
        check("tog_valid", 32'(valid), 32'd1);
        check("tog_const", 32'(rnd), 32'h77);
        sb_check("word_tog");

        // reset in HOLD and mid-fill
        rst = 1'b1;
        ready = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b0;
        check("rst_hold_valid", 32'(valid), 32'd0);
        en = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        seed_load = 1'b1;
        seed = 8'h55;
        tick();
        rst = 1'b0;
        seed_load = 1'b0;
        check("midrst_state", 32'(state), 32'h2A);
        check("midrst_valid", 32'(valid), 32'd0);
        sb.push_back(gen_word(8'h2A));
        repeat (7) tick();
        check("midrst_notyet", 32'(valid), 32'd0);
        tick();
        check("midrst_wvalid", 32'(valid), 32'd1);
        sb_check("word_midrst");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning LFSR register width; legal range 4..32.
REQ-002 SHALL have parameter TAPS, default 8'hB8, meaning feedback tap mask (bit i set = state bit i feeds XOR); TAPS[WIDTH-1] SHALL be 1.
REQ-003 SHALL have parameter SEED, default 42, meaning reset/recovery state; SHALL be nonzero.
REQ-004 SHALL have parameter OUT_W, default 8, meaning bits per output word; legal range 1..32.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  input  1  synchronous, active-high reset.
REQ-007 en_i  input  1  step enable; LFSR advances only when high and the state machine permits.
REQ-008 seed_load_i  input  1  load seed_i into LFSR this cycle.
REQ-009 seed_i  input  WIDTH  seed value for seed_load_i.
REQ-010 rand_valid_o  output  1  rand_o holds a complete word.
REQ-011 rand_ready_i  input  1  consumer accepts word when high with rand_valid_o.
REQ-012 rand_o  output  OUT_W  assembled random word.
REQ-013 state_o  output  WIDTH  current LFSR register contents.
REQ-014 lockup_o  output  1  one-cycle pulse: zero seed rejected, SEED substituted.

Function
REQ-015 Step rule SHALL be Fibonacci: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}.
REQ-016 Each step SHALL shift fb into LSB of an OUT_W-bit collector (first bit ends at MSB) and increment a bit counter.
REQ-017 FSM SHALL have two states: FILL and HOLD.
REQ-018 FILL: when en_i=1, SHALL step LFSR and collector; when en_i=0, SHALL hold all state.
REQ-019 On the step that makes the counter reach OUT_W, SHALL load rand_o with the completed collector value, set rand_valid_o=1 next cycle, clear counter, enter HOLD.
REQ-020 Latency: first valid word SHALL appear exactly OUT_W enabled cycles after entering FILL.
REQ-021 HOLD: LFSR, collector and rand_o SHALL be frozen regardless of en_i; rand_o SHALL stay stable while rand_valid_o=1 and rand_ready_i=0.
REQ-022 HOLD with rand_ready_i=1: handshake completes; next cycle rand_valid_o=0, FSM=FILL; no step occurs in the handshake cycle.
REQ-023 rand_ready_i SHALL be ignored while rand_valid_o=0.
REQ-024 seed_load_i SHALL have priority over stepping and handshake: LFSR <= seed_i, counter and collector cleared, rand_valid_o <= 0 (pending word discarded), FSM <= FILL.
REQ-025 seed_load_i with seed_i==0 SHALL load SEED instead and assert lockup_o for exactly one cycle.
REQ-026 lockup_o SHALL be 0 in all other cycles.
REQ-027 state_o SHALL equal the LFSR register at all times.
REQ-028 Counter width SHALL hold 0..OUT_W without overflow.

Reset
REQ-029 rst_i=1 at a clock edge SHALL set LFSR=SEED, collector=0, counter=0, rand_o=0, rand_valid_o=0, lockup_o=0, FSM=FILL.
REQ-030 rst_i SHALL override seed_load_i, en_i and rand_ready_i, including mid-fill and in HOLD.

Verification
REQ-031 Defaults, reset, en_i=1 -> state_o sequence 0x2A, 0x54, 0xA9, 0x53, 0xA7, 0x4E, 0x9D, 0x3B, 0x77; rand_valid_o=1 with rand_o=0x77 after 8th step.
REQ-032 Defaults, rand_ready_i=0 for 5 cycles in HOLD -> rand_o=0x77, state_o=0x77 stable; ready=1 -> valid drops next cycle, stepping resumes from 0x77.
REQ-033 OUT_W=4, defaults otherwise -> first word 0x7 after 4 steps (fb bits 0,1,1,1), state_o=0xA7.
REQ-034 seed_load_i=1, seed_i=0x00 -> state_o=0x2A next cycle, lockup_o high exactly one cycle.
REQ-035 seed_load_i=1, seed_i=0x01 while in HOLD with rand_ready_i=1 -> word discarded, rand_valid_o=0, state_o=0x01, FSM=FILL.
REQ-036 en_i toggled 1/0 every cycle from reset -> valid after 8 enabled cycles (16 clocks), rand_o=0x77; rst_i mid-fill -> state_o=0x2A, counter restarts.
